// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants and the control struct that stages pack into their payload.
//   RD_W_DEF    default destination register index width
//   X0          index of the hard-wired zero register, also the reset value of rd
//   pipe_ctrl_t per-instruction control bits (reg_write, mem_to_reg, mem_read, mem_write)
package pipe_pkg;
    localparam int RD_W_DEF = 5;
    localparam logic [RD_W_DEF-1:0] X0 = '0;
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } pipe_ctrl_t;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready handshake carrying a payload word and destination register index.
//   valid  entry valid (producer -> consumer)
//   ready  consumer accepts (consumer -> producer)
//   data   payload, DATA_W bits
//   rd     destination register index, RD_W bits
//   master modport drives valid/data/rd; slave modport drives ready.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int RD_W   = RD_W_DEF
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    modport master (output valid, data, rd, input ready);
    modport slave  (input valid, data, rd, output ready);
endinterface

// File: rtl/pipe_skid_slot.sv
// pipe_skid_slot: one payload+rd register with a valid bit, used as the overflow entry of a stage.
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clear          drop the held entry (highest priority)
//   load           capture data/rd and mark valid
//   unload         entry has moved on, mark empty
//   data, rd       entry to capture
//   valid, data_q, rd_q  held entry
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int RD_W   = RD_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear,
    input  logic              load,
    input  logic              unload,
    input  logic [DATA_W-1:0] data,
    input  logic [RD_W-1:0]   rd,
    output logic              valid,
    output logic [DATA_W-1:0] data_q,
    output logic [RD_W-1:0]   rd_q
);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid  <= 1'b0;
            data_q <= '0;
            rd_q   <= RD_W'(X0);
        end else begin
            if (clear) valid <= 1'b0;
            else if (load) valid <= 1'b1;
            else if (unload) valid <= 1'b0;
            if (load) begin
                data_q <= data;
                rd_q   <= rd;
            end
        end
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline register between stages with stall, flush and a stall counter.
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   flush_i      kill held and incoming entries
//   stall_i      hold stage contents
//   up           upstream handshake (slave): valid/data/rd in, ready out
//   dn           downstream handshake (master): valid/data/rd out, ready in
//   stall_cnt_o  saturating count of edges with stall_i or a blocked output
// Build option PIPE_SKID_EN: adds a second entry so ready is registered (no ready_i->ready_o path).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int RD_W   = RD_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     stall_i,
    pipe_stage_reg_if.slave          up,
    pipe_stage_reg_if.master         dn,
    output logic [CNT_W-1:0]         stall_cnt_o
);
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [RD_W-1:0]   rd_q;
    logic              accept;
    logic              advance;
    logic              take;
    logic [DATA_W-1:0] src_data;
    logic [RD_W-1:0]   src_rd;

    assign dn.valid = valid_q;
    assign dn.data  = data_q;
    assign dn.rd    = rd_q;
    assign accept   = up.valid & up.ready;
    // main slot may be rewritten this edge: empty or draining, and not stalled
    assign advance  = ~stall_i & (~valid_q | dn.ready);

`ifdef PIPE_SKID_EN
    logic              skid_v;
    logic [DATA_W-1:0] skid_d;
    logic [RD_W-1:0]   skid_r;

    // skid_v is a flop, so ready never depends on dn.ready
    assign up.ready = ~stall_i & ~skid_v;
    // the skid entry is older than anything arriving, so it refills the main slot first
    assign take     = skid_v | accept;
    assign src_data = skid_v ? skid_d : up.data;
    assign src_rd   = skid_v ? skid_r : up.rd;

    pipe_skid_slot #(.DATA_W(DATA_W), .RD_W(RD_W)) u_skid (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (flush_i),
        .load   (accept & ~advance),
        .unload (advance & skid_v),
        .data   (up.data),
        .rd     (up.rd),
        .valid  (skid_v),
        .data_q (skid_d),
        .rd_q   (skid_r)
    );
`else
    assign up.ready = advance;
    assign take     = accept;
    assign src_data = up.data;
    assign src_rd   = up.rd;
`endif

    // data_q/rd_q are left untouched on flush and bubbles; valid_q alone qualifies them
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            rd_q    <= RD_W'(X0);
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (advance) begin
            valid_q <= take;
            if (take) begin
                data_q <= src_data;
                rd_q   <= src_rd;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stall_cnt_o <= '0;
        else if ((stall_i | (valid_q & ~dn.ready)) & ~&stall_cnt_o) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vector table, corner sequences and a queue-model random run.
module tb_pipe_stage_reg;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fl = 1'b0;
    logic        st = 1'b0;
    logic        vi = 1'b0;
    logic        ri = 1'b0;
    logic [63:0] di = '0;
    logic [4:0]  rdi = '0;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(64), .RD_W(5)) up_a ();
    pipe_stage_reg_if #(.DATA_W(64), .RD_W(5)) dn_a ();
    pipe_stage_reg_if #(.DATA_W(64), .RD_W(5)) up_b ();
    pipe_stage_reg_if #(.DATA_W(64), .RD_W(5)) dn_b ();

    assign up_a.valid = vi;
    assign up_a.data  = di;
    assign up_a.rd    = rdi;
    assign dn_a.ready = ri;
    assign up_b.valid = vi;
    assign up_b.data  = di;
    assign up_b.rd    = rdi;
    assign dn_b.ready = ri;

    pipe_stage_reg dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(fl), .stall_i(st),
        .up(up_a), .dn(dn_a), .stall_cnt_o(cnt_a)
    );

    pipe_stage_reg #(.CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(fl), .stall_i(st),
        .up(up_b), .dn(dn_b), .stall_cnt_o(cnt_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic s, input logic f, input logic [63:0] d);
        vi = v;
        ri = r;
        st = s;
        fl = f;
        di = d;
        rdi = ~d[4:0];
    endtask

    task automatic chk_out(input string name, input logic v, input logic [63:0] d);
        logic [4:0] r;
        r = ~d[4:0];
        chk({name, "_valid"}, dn_a.valid, v);
        chk({name, "_data"}, dn_a.data, d);
        chk({name, "_rd"}, dn_a.rd, r);
    endtask

    typedef struct {
        logic        vi, ri, st, fl;
        logic [63:0] d;
        logic        rdy, v;
        logic [63:0] ed;
        int          cnt;
    } vec_t;
    vec_t tbl[14];

    // reference model: an ordered queue of held entries, plus what the output register last showed
    logic [63:0] q[$];
    logic [63:0] out_d;
    logic [4:0]  out_rd;
    int          mcnt;

    task automatic model_reset();
        q.delete();
        out_d = '0;
        out_rd = '0;
        mcnt = 0;
    endtask

    task automatic rstep();
        logic mrdy, acc, drn;
        @(negedge clk);
        drive($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 15) == 0, {$urandom, $urandom});
        mrdy = !st && (SKID ? q.size() < 2 : (q.size() == 0 || ri));
        #1 chk("rand_ready", up_a.ready, mrdy);
        acc = vi && mrdy;
        drn = q.size() > 0 && ri && !st;
        if (st || (q.size() > 0 && !ri)) mcnt++;
        if (fl) q.delete();
        else if (!st) begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(di);
        end
        if (q.size() > 0) begin
            out_d = q[0];
            out_rd = ~out_d[4:0];
        end
        @(posedge clk);
        #1;
        chk("rand_valid", dn_a.valid, q.size() > 0);
        chk("rand_data", dn_a.data, out_d);
        chk("rand_rd", dn_a.rd, out_rd);
        chk("rand_cnt16", cnt_a, mcnt > 65535 ? 65535 : mcnt);
        chk("rand_cnt4", cnt_b, mcnt > 15 ? 15 : mcnt);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h11, 1'b1, 1'b1, 64'h11, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h22, 1'b1, 1'b1, 64'h22, 0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h33, 1'b1, 1'b1, 64'h33, 0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 64'hAA, 1'b1, 1'b1, 64'hAA, 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 1'b1, 64'hAA, 1};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 1'b1, 64'hAA, 2};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 1'b1, 64'hAA, 3};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 1'b1, 64'hAA, 4};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'hAA, 4};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h55, 1'b1, 1'b1, 64'h55, 4};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 64'h66, 1'b0, 1'b0, 64'h55, 5};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h55, 5};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 64'h77, 1'b1, 1'b0, 64'h55, 5};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h55, 5};

        #2;
        chk("reset_valid", dn_a.valid, 1'b0);
        chk("reset_data", dn_a.data, 64'h0);
        chk("reset_rd", dn_a.rd, 5'h0);
        chk("reset_cnt", cnt_a, 16'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(tbl[i].vi, tbl[i].ri, tbl[i].st, tbl[i].fl, tbl[i].d);
            #1 chk($sformatf("vec%0d_ready", i), up_a.ready, tbl[i].rdy);
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].ed);
            chk($sformatf("vec%0d_cnt16", i), cnt_a, tbl[i].cnt);
            chk($sformatf("vec%0d_cnt4", i), cnt_b, tbl[i].cnt);
        end

        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'hC0);
        @(posedge clk);
        repeat (20) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
            @(posedge clk);
        end
        #1;
        chk_out("blocked_hold", 1'b1, 64'hC0);
        chk("sat_cnt4", cnt_b, 4'd15);
        chk("blocked_cnt16", cnt_a, 16'd25);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        @(posedge clk);
        #1 chk_out("blocked_drain", 1'b0, 64'hC0);

`ifdef PIPE_SKID_EN
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h01);
        #1 chk("skid_rdy0", up_a.ready, 1'b1);
        @(posedge clk);
        #1 chk_out("skid_a", 1'b1, 64'h01);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h02);
        #1 chk("skid_rdy1", up_a.ready, 1'b1);
        @(posedge clk);
        #1 chk_out("skid_b", 1'b1, 64'h01);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        #1 chk("skid_full_rdy", up_a.ready, 1'b0);
        @(posedge clk);
        #1 chk_out("skid_c", 1'b1, 64'h02);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        @(posedge clk);
        #1 chk_out("skid_d", 1'b0, 64'h02);
`endif

        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'hEE);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", dn_a.valid, 1'b0);
        chk("midrst_data", dn_a.data, 64'h0);
        chk("midrst_rd", dn_a.rd, 5'h0);
        chk("midrst_cnt16", cnt_a, 16'h0);
        chk("midrst_cnt4", cnt_b, 4'h0);
        #1 rst = 1'b0;
        model_reset();

        repeat (400) rstep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
